// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: controller state encoding.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle with start/busy/done handshake; ovf exists only with SERIAL_SUBTRACTOR_OVF_EN.
interface serial_subtractor_if #(parameter int N = 4);

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;

    modport master (output start, a, b, bin, input busy, done, d, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, d, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, d, bout);
    modport slave  (input start, a, b, bin, output busy, done, d, bout);
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, purely combinational.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial d = a - b - bin, LSB first, one cell + borrow flop; ovf port with SERIAL_SUBTRACTOR_OVF_EN.
// Latency N cycles from accepting edge to done; start is ignored (not queued) while busy.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave io
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q;
    state_e        state_nx;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  r_sr;
    logic [N-1:0]  r_nx;
    logic [N-1:0]  d_q;
    logic          br_q;
    logic          bout_q;
    logic          diff;
    logic          br_nx;
    logic          accept;
    logic          last;
    logic          busy_c;
    logic          done_c;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br_q),
        .d    (diff),
        .bout (br_nx)
    );

    assign accept = (state_q != SHIFT) && io.start;
    assign last   = (state_q == SHIFT) && (cnt_q == LAST);
    // New difference bit enters at the MSB; after N shifts bit 0 sits at the LSB.
    assign r_nx   = N'({diff, r_sr} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE, DONE: state_nx = io.start ? SHIFT : IDLE;
            SHIFT:      state_nx = last ? DONE : SHIFT;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_q)
            SHIFT:   busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            br_q   <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            a_sr  <= io.a;
            b_sr  <= io.b;
            br_q  <= io.bin;
        end else if (state_q == SHIFT) begin
            cnt_q <= cnt_q + 1'b1;
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= r_nx;
            br_q  <= br_nx;
            if (last) begin
                d_q    <= r_nx;
                bout_q <= br_nx;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ovf_q;

    // On the last shift br_q is the borrow into the MSB and br_nx the borrow out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ovf_q <= 1'b0;
        else if (last) ovf_q <= br_q ^ br_nx;
    end

    assign io.ovf = ovf_q;
`endif

    assign io.busy = busy_c;
    assign io.done = done_c;
    assign io.d    = d_q;
    assign io.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized + directed scoreboard bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] d;
        logic         bout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;
    exp_t sb_q[$];
    logic [N-1:0] last_d;

    serial_subtractor_if #(.N(N)) ifc ();

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input logic [N-1:0] aa, input logic [N-1:0] bb,
                                   input logic bi, input int c);
        exp_t m;
        int ua, ub, df, sa, sb, sd;
        ua = int'(aa);
        ub = int'(bb);
        df = ua - ub - int'(bi);
        m.d    = df[N-1:0];
        m.bout = (df < 0);
        sa = (ua >= 2 ** (N - 1)) ? ua - 2 ** N : ua;
        sb = (ub >= 2 ** (N - 1)) ? ub - 2 ** N : ub;
        sd = sa - sb - int'(bi);
        m.ovf = (sd < -(2 ** (N - 1))) || (sd > 2 ** (N - 1) - 1);
        m.cyc = c;
        return m;
    endfunction

    // Called just after a negedge; an idle/done DUT accepts at the coming posedge.
    task automatic drive_cycle(input logic s, input logic [N-1:0] aa,
                               input logic [N-1:0] bb, input logic bi);
        ifc.start = s;
        ifc.a     = aa;
        ifc.b     = bb;
        ifc.bin   = bi;
        if (s && !ifc.busy) sb_q.push_back(model(aa, bb, bi, cyc + 1 + N));
        @(negedge clk);
    endtask

    task automatic op(input logic [N-1:0] aa, input logic [N-1:0] bb, input logic bi);
        drive_cycle(1'b1, aa, bb, bi);
        repeat (N + 1) drive_cycle(1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: pops an expectation on every done pulse and checks hold behaviour while busy.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_done_excl", {31'd0, ifc.busy & ifc.done}, 32'd0);
            if (ifc.busy) chk("d_hold_busy", {28'd0, ifc.d}, {28'd0, last_d});
            if (ifc.done) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("d", {28'd0, ifc.d}, {28'd0, e.d});
                    chk("bout", {31'd0, ifc.bout}, {31'd0, e.bout});
                    chk("latency_cycle", cyc, e.cyc);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    chk("ovf", {31'd0, ifc.ovf}, {31'd0, e.ovf});
`endif
                end
                last_d = ifc.d;
            end
        end
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        last_d    = '0;
        rst_n     = 1'b0;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        ifc.bin   = 1'b0;
        #3;
        chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("rst_done", {31'd0, ifc.done}, 32'd0);
        chk("rst_d", {28'd0, ifc.d}, 32'd0);
        chk("rst_bout", {31'd0, ifc.bout}, 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("rst_ovf", {31'd0, ifc.ovf}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op(4'd3, 4'd2, 1'b0);
        op(4'd2, 4'd3, 1'b0);
        op(4'd0, 4'd0, 1'b1);
        op(4'h8, 4'h7, 1'b1);
        op(4'd3, 4'd2, 1'b0);

        // Abort on the 2nd SHIFT cycle: outputs clear asynchronously, no done follows.
        drive_cycle(1'b1, 4'd9, 4'd4, 1'b0);
        ifc.start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, ifc.busy}, 32'd0);
        chk("abort_done", {31'd0, ifc.done}, 32'd0);
        chk("abort_d", {28'd0, ifc.d}, 32'd0);
        chk("abort_bout", {31'd0, ifc.bout}, 32'd0);
        sb_q.delete();
        last_d = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (N + 3) drive_cycle(1'b0, '0, '0, 1'b0);
        op(4'd5, 4'd3, 1'b0);

        // start held high with changing operands: only IDLE/DONE edges take operands.
        repeat (4 * (N + 1)) drive_cycle(1'b1, N'($urandom), N'($urandom), 1'($urandom));
        repeat (N + 1) drive_cycle(1'b0, '0, '0, 1'b0);

        repeat (200) drive_cycle(1'($urandom), N'($urandom), N'($urandom), 1'($urandom));
        ifc.start = 1'b0;

        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
